// File: rtl/logic74_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package    : logic74_pkg                                             |
// | Description: Shared constants and helpers for the 74xx logic library |
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
package logic74_pkg;

  // Number of AND sections in the dual 74x08-style block.
  localparam int GATE_COUNT = 2;

  // Widest vector the shared helpers are meant to handle.
  localparam int LOGIC74_MAX_W = 16;

  // Bitwise AND of two vectors. Narrower users zero-extend their operands.
  // A 0 on either side forces a 0 even when the other side is X/Z.
  function automatic logic [LOGIC74_MAX_W-1:0] and_vec(
    input logic [LOGIC74_MAX_W-1:0] a,
    input logic [LOGIC74_MAX_W-1:0] b
  );
    return a & b;
  endfunction

endpackage : logic74_pkg
`default_nettype wire

// File: rtl/and2_gate.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : and2_gate                                               |
// | Description: Single 2-input AND section, purely combinational        |
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module and2_gate (
  input  logic a,
  input  logic b,
  output logic y
);

  // Plain '&' keeps standard X/Z semantics: a 0 on either input wins.
  assign y = a & b;

endmodule : and2_gate
`default_nettype wire

// File: rtl/mod_74x08_2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : mod_74x08_2                                             |
// | Description: Dual 2-input AND block with combinational output Y,     |
// |              registered shadow Y_Q and per-gate change pulses CHG.   |
// |              Bit 0 = gate 1, bit 1 = gate 2 (ascending index).       |
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module mod_74x08_2
  import logic74_pkg::*;
#(
  parameter int GATES = GATE_COUNT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [0:GATES-1] A,
  input  logic [0:GATES-1] B,
  output logic [0:GATES-1] Y,
  output logic [0:GATES-1] Y_Q,
  output logic [0:GATES-1] CHG
);

  logic [0:GATES-1] w_y;
  logic [0:GATES-1] r_y_q;
  logic [0:GATES-1] r_chg;

  // One independent AND section per gate; no clock or reset on this path.
  generate
    for (genvar gi = 0; gi < GATES; gi++) begin : g_gate
      and2_gate u_and2 (
        .a (A[gi]),
        .b (B[gi]),
        .y (w_y[gi])
      );
    end
  endgenerate

  assign Y = w_y;

  // Shadow register of Y; CHG flags bits where Y differs from the
  // pre-edge shadow, giving a one-cycle pulse per detected transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y_q <= '0;
      r_chg <= '0;
    end else begin
      r_y_q <= w_y;
      r_chg <= w_y ^ r_y_q;
    end
  end

  assign Y_Q = r_y_q;
  assign CHG = r_chg;

endmodule : mod_74x08_2
`default_nettype wire

// File: tb/tb_mod_74x08_2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : tb_mod_74x08_2                                          |
// | Description: Directed self-checking bench for mod_74x08_2            |
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module tb_mod_74x08_2;

  logic       clk;
  logic       clk_run;
  logic       rst_n;
  logic [0:1] A;
  logic [0:1] B;
  logic [0:1] Y;
  logic [0:1] Y_Q;
  logic [0:1] CHG;

  int checks;
  int errors;

  mod_74x08_2 #(.GATES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (A),
    .B     (B),
    .Y     (Y),
    .Y_Q   (Y_Q),
    .CHG   (CHG)
  );

  // Clock can be held static for the purely combinational checks.
  initial clk = 1'b0;
  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  task automatic check(input string tag, input logic [0:1] obs, input logic [0:1] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    clk_run = 1'b0;
    rst_n   = 1'b0;
    A       = 2'b00;
    B       = 2'b00;
    #1;
    check("reset_y_q", Y_Q, 2'b00);
    check("reset_chg", CHG, 2'b00);
    check("reset_y",   Y,   2'b00);

    // Gate 1 truth table
    A = 2'b10; B = 2'b10; #20; check("g1_11", Y, 2'b10);
    A = 2'b00; B = 2'b10; #20; check("g1_01", Y, 2'b00);
    A = 2'b10; B = 2'b00; #20; check("g1_10", Y, 2'b00);
    A = 2'b00; B = 2'b00; #20; check("g1_00", Y, 2'b00);

    // Gate 2 truth table
    A = 2'b01; B = 2'b01; #20; check("g2_11", Y, 2'b01);
    A = 2'b00; B = 2'b01; #20; check("g2_01", Y, 2'b00);
    A = 2'b01; B = 2'b00; #20; check("g2_10", Y, 2'b00);
    A = 2'b00; B = 2'b00; #20; check("g2_00", Y, 2'b00);

    // Independence: dropping gate 2's B leaves gate 1 alone
    A = 2'b11; B = 2'b11; #20; check("indep_both", Y, 2'b11);
    B = 2'b10;            #20; check("indep_g2_off", Y, 2'b10);
    check("indep_g1_hold", {1'b0, Y[0]}, 2'b01);

    // X on one input with a 0 on the other forces 0
    A = 2'b0x; B = 2'bx0; #20; check("x_forced_0", Y, 2'b00);

    // Combinational with clock static and reset held
    A = 2'b11; B = 2'b11; #20;
    check("noclk_y",   Y,   2'b11);
    check("noclk_y_q", Y_Q, 2'b00);
    check("noclk_chg", CHG, 2'b00);

    // Register and change flag
    clk_run = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("first_y_q", Y_Q, 2'b11);
    check("first_chg", CHG, 2'b11);
    @(posedge clk); #1;
    check("steady_chg", CHG, 2'b00);
    check("steady_y_q", Y_Q, 2'b11);
    A = 2'b01; #1;
    check("pre_edge_y", Y, 2'b01);
    @(posedge clk); #1;
    check("fall_chg", CHG, 2'b10);
    check("fall_y_q", Y_Q, 2'b01);
    @(posedge clk); #1;
    check("fall_chg_pulse_end", CHG, 2'b00);

    // Back to 11, then asynchronous reset between edges
    A = 2'b11;
    @(posedge clk); #1;
    check("rise_chg", CHG, 2'b10);
    check("rise_y_q", Y_Q, 2'b11);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_y_q", Y_Q, 2'b00);
    check("async_chg", CHG, 2'b00);
    check("async_y",   Y,   2'b11);
    B = 2'b01; #1;
    check("async_y_tracks", Y, 2'b01);
    @(posedge clk); #1;
    check("held_y_q", Y_Q, 2'b00);
    check("held_chg", CHG, 2'b00);

    clk_run = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mod_74x08_2
`default_nettype wire
